port_op_unit: RTL
=================

Name: port_op_unit

Overview:
- Parametrised, sequential successor to the fixed 4-bit combinational port-test operator modules.
- Accepts operand pairs over a valid/ready handshake and applies a per-transaction selectable operation.
- Single-cycle ops are registered; div/mod run on an iterative restoring divider.
- Returns the result and its complement over a second valid/ready handshake.
- Used in systest benches to exercise port widths, signedness and instance connection styles on logic with real state.

Parameters:
- WIDTH, 4, operand/result width in bits, >= 2.
- SIGNED, 0, 1 = operands and lt/mul/div/mod are two's-complement signed; 0 = unsigned.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand transaction offered.
- in_ready  output  1  unit can accept a transaction this cycle.
- in_op  input  3  operation select: 0 xor, 1 and, 2 or, 3 lt, 4 mul, 5 div, 6 mod, 7 sel.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_valid  output  1  result held in output register.
- out_ready  input  1  consumer takes the result this cycle.
- out  output  WIDTH  result.
- out2  output  WIDTH  bitwise ~out, always consistent with out.
- busy  output  1  divider iterating.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset (sampled at clk edge):
  - state = IDLE; out_valid = 0; out = 0; out2 = all ones; busy = 0.
  - Divider registers cleared. Reset has priority over every other event, including mid-division: the division is abandoned and its result is never presented.
- in_ready = (state == IDLE) && (!out_valid || out_ready). This is combinational and has no dependency on in_valid.
- Accept = in_valid && in_ready. in1, in2 and in_op are sampled only on accept.
- Output drain = out_valid && out_ready. On drain with no new load, out_valid = 0 next cycle; out keeps its value.
- Same-cycle drain and accept are legal and give back-to-back throughput for ops 0-4 and 7.
- Ops 0-4 and 7 (latency 1): on accept, out is loaded with the result and out_valid = 1 next cycle.
  - xor / and / or: bitwise.
  - lt: {WIDTH-1 zeros, (in1 < in2)}, compared signed or unsigned per SIGNED.
  - mul: low WIDTH bits of the product. The low bits are identical for signed and unsigned.
  - sel: in1[1] ? (in1 ^ in2) : (in1 & in2).
- Ops 5/6 (div/mod):
  - On accept, state -> DIV and busy = 1.
  - SIGNED = 1: operands are converted to magnitudes and the signs recorded.
  - Exactly WIDTH iteration cycles follow, one quotient bit per cycle, MSB first.
  - On the last iteration cycle the fixed-up result is written to out, out_valid = 1, and state -> IDLE.
  - Accept-to-out_valid latency is WIDTH+1 cycles.
  - in_ready = 0 throughout DIV. out_valid is guaranteed 0 during DIV, because accept required the output slot to be free.
- Signed fix-up:
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of in1.
  - Overflow case min / -1: quotient = min (wraps), remainder = 0.
- Divide by zero (in2 == 0): div returns all ones and mod returns in1, in both modes. The normal WIDTH+1 latency applies.
- State machine: IDLE -(accept, op 5/6)-> DIV -(iteration count == WIDTH-1)-> IDLE. No other transitions exist apart from reset.
- Backpressure: while out_valid && !out_ready, out and out2 hold stable and in_ready = 0.
- Inputs are ignored when in_ready = 0. in_valid may be asserted or dropped freely; no stability rule is imposed on the producer.

Test Plan:
- WIDTH=4, SIGNED=0: reset, then op 4 with in1=3, in2=7 -> out=4'b0101, out2=4'b1010, out_valid 1 cycle after accept. Back-to-back op 0 with 4'b1100, 4'b1010 on the next cycle (out_ready=1) -> out=4'b0110 on the following cycle.
- WIDTH=4, SIGNED=0: op 5 with 13, 3 -> busy for 4 cycles, in_ready=0, out=4 at accept+5. Op 6 with 13, 3 -> out=1. Op 5 with 13, 0 -> out=4'b1111. Op 6 with 13, 0 -> out=13.
- WIDTH=4, SIGNED=1: op 5 with -7, 2 -> out=4'b1101 (-3). Op 6 with -7, 2 -> 4'b1111 (-1). Op 5 with -8, -1 -> 4'b1000. Op 3 with 4'b1000, 4'b0001 -> 4'b0001; the same op 3 operands with SIGNED=0 -> 4'b0000.
- Backpressure: hold out_ready=0 for 5 cycles after an op 7 result (in1=4'b0010, in2=4'b0111 -> out=4'b0101). out stays stable, in_ready=0, and a pending in_valid is not taken until the drain cycle.
- Reset mid-op: reset on the 2nd DIV cycle of 13/3 -> next cycle out_valid=0, busy=0, in_ready=1, out=0. No stale result appears afterwards.
- WIDTH=16, SIGNED=1: op 5 with -30000, 7 -> out=-4285 at accept+17. Random regression of all ops against a reference model, with random in_valid/out_ready.

Source files
------------

// File: rtl/port_op_unit.sv
// Two-operand op unit (xor/and/or/lt/mul/sel registered, div/mod via iterative restoring divider).
// Latency: 1 cycle for ops 0-4 and 7, WIDTH+1 cycles for div/mod (accept to out_valid).
// Backpressure: in_ready drops while the divider runs or the output register is full and not draining.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/in_op/in1/in2 operand handshake;
//        out_valid/out_ready/out/out2 result handshake (out2 = ~out); busy = divider iterating.
module port_op_unit #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out2,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_DIV} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quot_q, quot_d;   // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] a_raw_q, a_raw_d; // raw in1, returned by mod-by-zero
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_mod_q, is_mod_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;

  logic accept;
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Operand magnitudes for the divider; the most negative value maps onto
  // 2^(WIDTH-1), which is still correct when read as unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_neg = SIGNED && in1[WIDTH-1];
  assign b_neg = SIGNED && in2[WIDTH-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;

  // Single-cycle ALU
  logic [WIDTH-1:0] prod;
  logic             lt;
  logic [WIDTH-1:0] alu_res;
  assign prod = in1 * in2;  // low bits are sign-agnostic
  assign lt   = SIGNED ? ($signed(in1) < $signed(in2)) : (in1 < in2);

  always_comb begin
    alu_res = '0;
    unique case (in_op)
      3'd0:    alu_res = in1 ^ in2;
      3'd1:    alu_res = in1 & in2;
      3'd2:    alu_res = in1 | in2;
      3'd3:    alu_res = {{(WIDTH-1){1'b0}}, lt};
      3'd4:    alu_res = prod;
      default: alu_res = in1[1] ? (in1 ^ in2) : (in1 & in2);
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   rem_sh, trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx, quot_nx, q_fix, r_fix, div_res;
  assign rem_sh  = {rem_q, quot_q[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, dvs_q};
  assign q_bit   = ~trial[WIDTH];
  assign rem_nx  = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quot_nx = {quot_q[WIDTH-2:0], q_bit};
  // min / -1 needs no special case: magnitude 2^(WIDTH-1), unnegated, wraps to min.
  assign q_fix   = q_neg_q ? -quot_nx : quot_nx;
  assign r_fix   = r_neg_q ? -rem_nx : rem_nx;
  assign div_res = dbz_q ? (is_mod_q ? a_raw_q : '1) : (is_mod_q ? r_fix : q_fix);

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    a_raw_d     = a_raw_q;
    cnt_d       = cnt_q;
    is_mod_d    = is_mod_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          if (in_op == 3'd5 || in_op == 3'd6) begin
            state_d  = S_DIV;
            quot_d   = a_mag;
            rem_d    = '0;
            dvs_d    = b_mag;
            a_raw_d  = in1;
            cnt_d    = '0;
            is_mod_d = (in_op == 3'd6);
            q_neg_d  = a_neg ^ b_neg;
            r_neg_d  = a_neg;
            dbz_d    = (in2 == '0);
          end else begin
            out_d       = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      S_DIV: begin
        quot_d = quot_nx;
        rem_d  = rem_nx;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          out_d       = div_res;
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      a_raw_q     <= '0;
      cnt_q       <= '0;
      is_mod_q    <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      a_raw_q     <= a_raw_d;
      cnt_q       <= cnt_d;
      is_mod_q    <= is_mod_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dbz_q       <= dbz_d;
    end
  end

  assign out       = out_q;
  assign out2      = ~out_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_DIV);

endmodule
